// File: rtl/pipe_stage_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid_reg
//
// Purpose:
//   Parametrised inter-stage pipeline register with a valid/ready handshake
//   and a two-entry skid buffer. It carries a PC field, a control bundle and
//   a data bundle between two stages. Back-pressure from downstream reaches
//   upstream only through registered state, so there is no combinational
//   path from out_ready to in_ready. A synchronous flush squashes whatever
//   the stage holds. An empty or squashed stage always presents an all-zero
//   control bundle, which downstream treats as a bubble.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset; all state cleared while low
//   flush      in   synchronous squash of both entries
//   in_valid   in   upstream beat present
//   in_ready   out  stage can accept a beat (registered, NOT skid valid)
//   in_pc      in   upstream PC            [PC_W]
//   in_ctrl    in   upstream control       [CTRL_W]
//   in_data    in   upstream data          [DATA_W]
//   out_valid  out  main entry holds a live beat
//   out_ready  in   downstream consumes the beat this cycle
//   out_pc     out  registered PC          [PC_W]
//   out_ctrl   out  registered control     [CTRL_W], zero when out_valid=0
//   out_data   out  registered data        [DATA_W]
//
// Optional feature (macro PIPE_STAGE_PERF_EN):
//   stall_cnt  out  [32] cycles with out_valid=1 and out_ready=0
//   flush_cnt  out  [16] flush cycles that discarded at least one entry
//   Both saturate at all-ones and are cleared only by reset.
// ---------------------------------------------------------------------------
module pipe_stage_skid_reg #(
  parameter int unsigned        DATA_W = 96,
  parameter int unsigned        CTRL_W = 8,
  parameter int unsigned        PC_W   = 32,
  parameter logic [PC_W-1:0]    PC_RST = 32'h80000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_in_ready;
  logic              r_out_valid;

  // Main entry drives the outputs; skid entry holds the younger beat.
  logic [PC_W-1:0]   r_main_pc;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [PC_W-1:0]   r_skid_pc;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;

  logic              w_accept;
  logic              w_xfer;

  // Both handshake terms use only registered ready/valid, so in_ready never
  // depends combinationally on out_ready.
  assign w_accept = in_valid & r_in_ready;
  assign w_xfer   = r_out_valid & out_ready;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_pc    = r_main_pc;
  assign out_ctrl  = r_main_ctrl;
  assign out_data  = r_main_data;

  // Occupancy FSM plus entry storage. Flush wins over every handshake: a beat
  // accepted in the flush cycle is dropped, and a beat transferred out in the
  // same cycle has already been taken by downstream, so nothing extra is
  // needed for it. Whenever the stage becomes empty the main control bundle
  // is zeroed so the outputs show a bubble, while PC and data keep their last
  // value to avoid needless toggling on the wide buses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_main_pc   <= PC_RST;
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_pc   <= PC_RST;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else if (flush) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_main_ctrl <= '0;
      r_skid_ctrl <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_main_pc   <= in_pc;
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
            r_out_valid <= 1'b1;
            r_state     <= ST_ONE;
          end
        end

        ST_ONE: begin
          if (w_accept && w_xfer) begin
            r_main_pc   <= in_pc;
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
          end else if (w_accept) begin
            r_skid_pc   <= in_pc;
            r_skid_ctrl <= in_ctrl;
            r_skid_data <= in_data;
            r_in_ready  <= 1'b0;
            r_state     <= ST_TWO;
          end else if (w_xfer) begin
            r_main_ctrl <= '0;
            r_out_valid <= 1'b0;
            r_state     <= ST_EMPTY;
          end
        end

        ST_TWO: begin
          // in_ready is low here, so only a transfer-out can happen; the
          // older main beat leaves and the skid beat takes its place.
          if (w_xfer) begin
            r_main_pc   <= r_skid_pc;
            r_main_ctrl <= r_skid_ctrl;
            r_main_data <= r_skid_data;
            r_skid_ctrl <= '0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_ONE;
          end
        end

        default: begin
          r_state     <= ST_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_main_ctrl <= '0;
          r_skid_ctrl <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;
  logic        w_stall;
  logic        w_flush_discard;

  assign w_stall = r_out_valid & ~out_ready;

  // A flush discards something if the skid entry is live, or if the main
  // entry is live and is not being consumed in the same cycle.
  assign w_flush_discard = flush & ((r_state == ST_TWO) | w_stall);

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  // Saturating performance counters; flush does not clear them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_flush_discard && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid_reg
//
// Self-checking bench for pipe_stage_skid_reg. A reference model keeps the
// stage contents as a queue of at most two beats; outputs are derived from
// the queue head, and the last head is remembered for the held PC/data when
// the stage is empty. Inputs are driven on the falling edge and outputs are
// checked on the following falling edge.
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid_reg;

  localparam int unsigned DATA_W = 96;
  localparam int unsigned CTRL_W = 8;
  localparam int unsigned PC_W   = 32;
  localparam logic [PC_W-1:0] PC_RST = 32'h80000000;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]       stall_cnt;
  logic [15:0]       flush_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state.
  beat_t             q[$];
  logic [PC_W-1:0]   lastPc;
  logic [DATA_W-1:0] lastData;
  longint            expStall;
  longint            expFlush;

  pipe_stage_skid_reg #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .PC_W   (PC_W),
    .PC_RST (PC_RST)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges the run.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired before end of test");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog");
  end

  task automatic modelReset();
    q.delete();
    lastPc   = PC_RST;
    lastData = '0;
    expStall = 0;
    expFlush = 0;
  endtask

  task automatic applyStimulus(input logic v, input logic [PC_W-1:0] pc,
                               input logic [CTRL_W-1:0] ctrl,
                               input logic [DATA_W-1:0] data,
                               input logic ordy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_ctrl   = ctrl;
    in_data   = data;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic checkOutput(input string tag);
    logic              expValid;
    logic              expReady;
    logic [CTRL_W-1:0] expCtrl;
    logic [PC_W-1:0]   expPc;
    logic [DATA_W-1:0] expData;
    expValid = (q.size() != 0);
    expReady = (q.size() < 2);
    if (expValid) begin
      expCtrl = q[0].ctrl;
      expPc   = q[0].pc;
      expData = q[0].data;
    end else begin
      expCtrl = '0;
      expPc   = lastPc;
      expData = lastData;
    end
    checks++;
    assert (out_valid === expValid) else begin
      errors++;
      $error("[TB] FAIL %s out_valid got %0b want %0b", tag, out_valid, expValid);
    end
    checks++;
    assert (in_ready === expReady) else begin
      errors++;
      $error("[TB] FAIL %s in_ready got %0b want %0b", tag, in_ready, expReady);
    end
    checks++;
    assert (out_ctrl === expCtrl) else begin
      errors++;
      $error("[TB] FAIL %s out_ctrl got %h want %h", tag, out_ctrl, expCtrl);
    end
    checks++;
    assert (out_pc === expPc) else begin
      errors++;
      $error("[TB] FAIL %s out_pc got %h want %h", tag, out_pc, expPc);
    end
    checks++;
    assert (out_data === expData) else begin
      errors++;
      $error("[TB] FAIL %s out_data got %h want %h", tag, out_data, expData);
    end
`ifdef PIPE_STAGE_PERF_EN
    checks++;
    assert (stall_cnt === 32'(expStall)) else begin
      errors++;
      $error("[TB] FAIL %s stall_cnt got %0d want %0d", tag, stall_cnt, expStall);
    end
    checks++;
    assert (flush_cnt === 16'(expFlush)) else begin
      errors++;
      $error("[TB] FAIL %s flush_cnt got %0d want %0d", tag, flush_cnt, expFlush);
    end
`endif
  endtask

  // Advance the model by one rising edge using the currently driven inputs,
  // let the DUT take the same edge, then compare on the falling edge.
  task automatic stepCheck(input string tag);
    bit    acc;
    bit    xf;
    beat_t b;
    acc = in_valid && (q.size() < 2);
    xf  = (q.size() > 0) && out_ready;
    if (q.size() > 0 && !out_ready) expStall++;
    if (flush && (q.size() == 2 || (q.size() == 1 && !out_ready))) expFlush++;
    if (q.size() > 0) begin
      lastPc   = q[0].pc;
      lastData = q[0].data;
    end
    if (flush) begin
      q.delete();
    end else begin
      if (xf) void'(q.pop_front());
      if (acc) begin
        b.pc   = in_pc;
        b.ctrl = in_ctrl;
        b.data = in_data;
        q.push_back(b);
      end
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput(tag);
  endtask

  initial begin
    logic [DATA_W-1:0] rd;
    reset = 1'b0;
    applyStimulus(1'b1, 32'h1234_5678, 8'hFF, '1, 1'b0, 1'b0);
    modelReset();

    // Reset held low for three cycles with in_valid asserted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("reset_hold");
    end

    // Release and send a first beat.
    reset = 1'b1;
    applyStimulus(1'b1, 32'h8000_0004, 8'h11, 96'h4, 1'b0, 1'b0);
    stepCheck("first_beat");
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);
    stepCheck("first_drain");

    // Back-to-back streaming with out_ready held high.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 32'h8000_0100 + 32'(4 * i), 8'(i), 96'(i), 1'b1, 1'b0);
      stepCheck("stream");
    end
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);
    stepCheck("stream_drain");

    // Back-pressure: A and B queue up, then drain in order.
    applyStimulus(1'b1, 32'h8000_0A00, 8'h0A, 96'hAAAA, 1'b0, 1'b0);
    stepCheck("bp_A");
    applyStimulus(1'b1, 32'h8000_0B00, 8'h0B, 96'hBBBB, 1'b0, 1'b0);
    stepCheck("bp_B");
    applyStimulus(1'b1, 32'h8000_0C00, 8'h0C, 96'hCCCC, 1'b0, 1'b0);
    stepCheck("bp_full_hold");
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);
    stepCheck("bp_A_out");
    stepCheck("bp_B_out");

    // Flush in the full state while a new beat C is offered.
    applyStimulus(1'b1, 32'h8000_0D00, 8'h0D, 96'hDDDD, 1'b0, 1'b0);
    stepCheck("fl_fill1");
    applyStimulus(1'b1, 32'h8000_0E00, 8'h0E, 96'hEEEE, 1'b0, 1'b0);
    stepCheck("fl_fill2");
    applyStimulus(1'b1, 32'h8000_0F00, 8'h0F, 96'hCCC0, 1'b0, 1'b1);
    stepCheck("flush_two");
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);
    stepCheck("flush_after");

    // Bubble: one beat consumed with nothing behind it.
    applyStimulus(1'b1, 32'h8000_1000, 8'hA5, 96'h5A5A_5A5A, 1'b1, 1'b0);
    stepCheck("bubble_load");
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);
    stepCheck("bubble");

    // Asynchronous reset in the middle of traffic.
    applyStimulus(1'b1, 32'h8000_2000, 8'h22, 96'h2222, 1'b0, 1'b0);
    stepCheck("ar_fill1");
    stepCheck("ar_fill2");
    #2;
    reset = 1'b0;
    #1;
    modelReset();
    checkOutput("async_reset");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    checkOutput("async_release");
    applyStimulus(1'b1, 32'h8000_3000, 8'h33, 96'h3333, 1'b1, 1'b0);
    stepCheck("after_release");

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      rd = {$urandom, $urandom, $urandom};
      applyStimulus(1'($urandom_range(0, 3) != 0), 32'($urandom), 8'($urandom), rd,
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
      stepCheck("random");
    end

`ifdef PIPE_STAGE_PERF_EN
    // Counter checks from a clean reset.
    @(negedge clk);
    reset = 1'b0;
    #1;
    modelReset();
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1'b1, 32'h8000_4000, 8'h44, 96'h4444, 1'b0, 1'b0);
    stepCheck("perf_load");
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) stepCheck("perf_stall");
    checks++;
    assert (stall_cnt === 32'd5) else begin
      errors++;
      $error("[TB] FAIL perf_stall5 stall_cnt got %0d want 5", stall_cnt);
    end
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1);
    stepCheck("perf_flush");
    checks++;
    assert (flush_cnt === 16'd1) else begin
      errors++;
      $error("[TB] FAIL perf_flush1 flush_cnt got %0d want 1", flush_cnt);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers (ID/EX, EX/MEM, MEM/WB).
- Carries a PC field, a control bundle and a data bundle between two pipeline stages using a valid/ready handshake.
- A two-entry skid buffer lets back-pressure (load-use stall, multi-cycle memory) propagate without combinational ready paths.
- Synchronous flush squashes in-flight beats for branch/jump recovery; a squashed or empty stage presents an all-zero control bundle (bubble).

Parameters:
- DATA_W, 96: width of the data bundle (ALU result, BusB, register indices packed by the instantiating stage).
- CTRL_W, 8: width of the control bundle (MemWr, MemRd, RegWr, MemtoReg, jal, ...); forced to 0 on any bubble.
- PC_W, 32: width of the PC field.
- PC_RST, 32'h80000000: reset value of the PC field.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-low reset; all state cleared while low.
- flush  in  1  synchronous squash of both entries; highest priority after reset.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat; registered, equals NOT skid_valid.
- in_pc  in  PC_W  upstream PC.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  main entry holds a live beat.
- out_ready  in  1  downstream consumes the beat this cycle.
- out_pc  out  PC_W  registered PC.
- out_ctrl  out  CTRL_W  registered control bundle; 0 whenever out_valid=0.
- out_data  out  DATA_W  registered data bundle.

Behaviour:
- Storage: main entry (drives outputs) and skid entry; states EMPTY (none valid), ONE (main only), TWO (main+skid).
- Accept = in_valid & in_ready; transfer-out = out_valid & out_ready.
- EMPTY: accept -> ONE, beat loaded into main.
- ONE:
  - accept & transfer-out -> ONE, main reloaded.
  - accept only -> TWO, beat into skid, in_ready=0 next cycle.
  - transfer-out only -> EMPTY.
- TWO: in_ready=0 so no accept. Transfer-out -> ONE, skid moves to main, in_ready=1 next cycle.
- Latency: 1 cycle from accept to out_valid when EMPTY; sustained 1 beat/cycle while out_ready=1.
- Order preserved: main always older than skid.
- On entering EMPTY: out_ctrl cleared to 0; out_pc/out_data hold the last value.
- Flush (rising edge with flush=1):
  - both entries invalidated; out_valid=0, out_ctrl=0, in_ready=1 next cycle.
  - a beat accepted in the same cycle is discarded.
  - a simultaneous transfer-out still counts as consumed downstream.
- Reset low (any time, mid-transfer included), immediately and asynchronously:
  - out_valid=0, out_ctrl=0, out_data=0, out_pc=PC_RST, in_ready=1, state EMPTY.
- First edge after reset release behaves as EMPTY.
- No combinational path from out_ready to in_ready.
- in_* inputs are sampled only on accept; they may change freely otherwise.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - adds output stall_cnt (32 bits) counting cycles with out_valid=1 & out_ready=0.
  - adds output flush_cnt (16 bits) counting flush cycles that discard at least one valid entry.
  - both counters saturate at all-ones, cleared by reset, unaffected by flush.
- Not defined: ports and logic absent; the behaviour above is otherwise identical.

Test Plan:
- Reset: hold reset=0 three cycles with in_valid=1 -> out_valid=0, out_ctrl=0, out_pc=32'h80000000, in_ready=1. Release, send pc=0x80000004 -> out_pc=0x80000004 one cycle later.
- Streaming: out_ready=1, beats data=1..8 back-to-back -> out_data 1..8 on consecutive cycles, in_ready stays 1.
- Back-pressure:
  - with out_ready=0, send beats A,B -> in_ready=0 after B.
  - raise out_ready -> A then B emerge in order; in_ready=1 the cycle after A leaves.
- Flush in TWO state, with a new beat C offered the same cycle -> out_valid=0, out_ctrl=0 next cycle, C never appears, in_ready=1.
- Bubble: single beat ctrl=8'hA5 consumed with in_valid=0 -> next cycle out_valid=0, out_ctrl=0, out_data unchanged.
- With PIPE_STAGE_PERF_EN: out_ready=0 for 5 cycles with a valid beat held -> stall_cnt=5. One flush over valid data -> flush_cnt=1.
